// File: rtl/pattern_serializer_pkg.sv
// Shared types and helpers for the pattern serializer and its bench.
package pattern_ser_pkg;

    localparam int unsigned DEF_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic logic len_legal(input int unsigned len, input int unsigned width);
        return (len != 0) && (len <= width);
    endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Word handshake plus serial-side signals of the pattern serializer.
interface pattern_serializer_if
    import pattern_ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LEN_W-1:0] in_len;
    logic             shift_en;
    logic             data_out;
    logic             out_valid;
    logic             last_bit;
    logic             busy;
    logic             err_len;

    modport master (
        output in_valid, in_data, in_len, shift_en,
        input  in_ready, data_out, out_valid, last_bit, busy, err_len
    );

    modport slave (
        input  in_valid, in_data, in_len, shift_en,
        output in_ready, data_out, out_valid, last_bit, busy, err_len
    );
endinterface

// File: rtl/pattern_serializer_hold_buf.sv
// Single-entry hold register (aligned data + length) with a full flag.
module ser_hold_buf #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d_data,
    input  logic [LEN_W-1:0] d_len,
    output logic [WIDTH-1:0] q_data,
    output logic [LEN_W-1:0] q_len,
    output logic             full
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        len_d  = len_q;
        if (load) begin
            full_d = 1'b1;
            data_d = d_data;
            len_d  = d_len;
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            len_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            len_q  <= len_d;
        end
    end

    assign q_data = data_q;
    assign q_len  = len_q;
    assign full   = full_q;
endmodule

// File: rtl/pattern_serializer.sv
// MSB-first parallel-to-serial stage with a one-word hold buffer for gap-free streaming.
module pattern_serializer
    import pattern_ser_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    pattern_serializer_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_len_q, err_len_d;

    logic [WIDTH-1:0] aligned, hold_data;
    logic [LEN_W-1:0] hold_len;
    logic             hold_full, hold_load, hold_drain;
    logic             accept, legal, acc_legal, word_end;

    assign bus.in_ready = rst_n & ~hold_full;
    assign accept       = bus.in_valid & bus.in_ready;
    assign legal        = len_legal(32'(bus.in_len), WIDTH);
    assign acc_legal    = accept & legal;
    // Words are stored pre-aligned so the hold buffer drains straight into shreg.
    assign aligned      = bus.in_data << (LEN_W'(WIDTH) - bus.in_len);
    assign word_end     = (state_q == SHIFT) & bus.shift_en & (cnt_q == LEN_W'(1));
    assign hold_load    = acc_legal & (state_q == SHIFT) & ~word_end;
    assign hold_drain   = word_end & hold_full;

    ser_hold_buf #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (hold_load),
        .drain  (hold_drain),
        .d_data (aligned),
        .d_len  (bus.in_len),
        .q_data (hold_data),
        .q_len  (hold_len),
        .full   (hold_full)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        err_len_d = accept & ~legal;
        // in_ready is low while hold is full, so a drain never coincides with an accept.
        if (hold_drain) begin
            shreg_d = hold_data;
            cnt_d   = hold_len;
            state_d = SHIFT;
        end else if (acc_legal && ((state_q == IDLE) || word_end)) begin
            shreg_d = aligned;
            cnt_d   = bus.in_len;
            state_d = SHIFT;
        end else if (word_end) begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if ((state_q == SHIFT) && bus.shift_en) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            err_len_q <= err_len_d;
        end
    end

    assign bus.out_valid = (state_q == SHIFT);
    assign bus.data_out  = (state_q == SHIFT) & shreg_q[WIDTH-1];
    assign bus.last_bit  = (state_q == SHIFT) & (cnt_q == LEN_W'(1));
    assign bus.busy      = (state_q == SHIFT) | hold_full;
    assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: bit-queue reference model plus directed and random streams.
module tb_pattern_serializer;
    import pattern_ser_pkg::*;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pattern_serializer_if #(.WIDTH(WIDTH)) bus ();

    pattern_serializer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: every accepted legal word becomes its bits in send order.
    bit exp_bits[$];
    bit exp_last[$];
    int words = 0;
    bit err_exp = 1'b0;
    bit acc_flag = 1'b0;

    // Observed consumed bits, for the hand-computed literal checks.
    bit seen[$];
    int seen_last = 0;
    bit samp_valid = 1'b0;
    bit samp_bit = 1'b0;
    bit samp_last = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int err_seen = 0;
    int ready_low_seen = 0;
    int mode = 2;
    bit man_shift = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_bits.delete();
            exp_last.delete();
            words = 0;
            err_exp = 1'b0;
            acc_flag = 1'b0;
        end else begin
            bit acc;
            int len;
            if (samp_valid && bus.shift_en) begin
                seen.push_back(samp_bit);
                if (samp_last) seen_last++;
            end
            acc = bus.in_valid && (words < 2);
            acc_flag = acc;
            err_exp = 1'b0;
            if (exp_bits.size() > 0 && bus.shift_en) begin
                if (exp_last[0]) words--;
                void'(exp_bits.pop_front());
                void'(exp_last.pop_front());
            end
            if (acc) begin
                len = int'(bus.in_len);
                if (len_legal(len, WIDTH)) begin
                    for (int i = len - 1; i >= 0; i--) begin
                        exp_bits.push_back(bus.in_data[i]);
                        exp_last.push_back(i == 0);
                    end
                    words++;
                end else begin
                    err_exp = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One clock: compare at the falling edge, then drive shift_en for the next rising edge.
    task automatic tick();
        bit ev;
        @(negedge clk);
        if (rst_n) begin
            ev = exp_bits.size() > 0;
            check("out_valid", bus.out_valid, ev);
            check("data_out", bus.data_out, ev ? exp_bits[0] : 1'b0);
            check("last_bit", bus.last_bit, ev ? exp_last[0] : 1'b0);
            check("busy", bus.busy, ev);
            check("in_ready", bus.in_ready, words < 2);
            check("err_len", bus.err_len, err_exp);
            if (bus.err_len) err_seen++;
            if (!bus.in_ready) ready_low_seen++;
            samp_valid = bus.out_valid;
            samp_bit = bus.data_out;
            samp_last = bus.last_bit;
        end else begin
            samp_valid = 1'b0;
        end
        #2;
        case (mode)
            0:       bus.shift_en = 1'b1;
            1:       bus.shift_en = 1'($urandom_range(0, 1));
            default: bus.shift_en = man_shift;
        endcase
    endtask

    task automatic send_word(input logic [WIDTH-1:0] data, input int len);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = data;
        bus.in_len = 5'(len);
        for (int c = 0; c < 500 && !done; c++) begin
            tick();
            done = acc_flag;
        end
        if (!done) check("handshake_timeout", 1'b0, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 2000 && exp_bits.size() > 0; c++) tick();
        check("drain_timeout", exp_bits.size() == 0, 1'b1);
        tick();
    endtask

    function automatic int pack_seen(input int start, input int n);
        int r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | int'(seen[start + i]);
        return r;
    endfunction

    initial begin
        int s0, l0, e0, total_bits;
        logic [WIDTH-1:0] rd;
        int rl;
        bit s3[7] = '{1, 0, 0, 1, 1, 0, 1};

        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_len = '0;
        bus.shift_en = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // 1: single 10-bit word
        mode = 0;
        s0 = seen.size(); l0 = seen_last;
        send_word(16'h02B3, 10);
        drain();
        check_int("t1_count", seen.size() - s0, 10);
        check_int("t1_stream", pack_seen(s0, 10), 10'b1010110011);
        check_int("t1_last", seen_last - l0, 1);

        // 2: back-to-back
        s0 = seen.size(); l0 = ready_low_seen;
        send_word(16'h0015, 5);
        send_word(16'h0015, 5);
        drain();
        check_int("t2_stream", pack_seen(s0, 10), 10'b1010110101);
        check("t2_ready_low", ready_low_seen > l0, 1'b1);

        // 3: stall
        mode = 2; man_shift = 1'b0;
        tick();
        s0 = seen.size();
        send_word(16'h0009, 4);
        foreach (s3[i]) begin
            man_shift = s3[i];
            tick();
        end
        man_shift = 1'b0;
        tick();
        check_int("t3_count", seen.size() - s0, 4);
        check_int("t3_stream", pack_seen(s0, 4), 4'b1001);
        check("t3_idle", bus.out_valid, 1'b0);

        // 4: illegal lengths
        mode = 0;
        s0 = seen.size(); e0 = err_seen;
        send_word(16'hABCD, 0);
        send_word(16'hABCD, 17);
        tick(); tick();
        check_int("t4_err_pulses", err_seen - e0, 2);
        check_int("t4_no_bits", seen.size() - s0, 0);

        // 5: reset mid-word
        s0 = seen.size();
        send_word(16'hFFFF, 16);
        for (int c = 0; c < 100 && seen.size() - s0 < 3; c++) tick();
        check_int("t5_bits_before_rst", seen.size() - s0, 3);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", bus.out_valid, 1'b0);
        check("t5_rst_data_out", bus.data_out, 1'b0);
        check("t5_rst_last_bit", bus.last_bit, 1'b0);
        check("t5_rst_busy", bus.busy, 1'b0);
        check("t5_rst_in_ready", bus.in_ready, 1'b0);
        check("t5_rst_err_len", bus.err_len, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_post_in_ready", bus.in_ready, 1'b1);
        check("t5_post_out_valid", bus.out_valid, 1'b0);

        // 6: random stream
        mode = 1;
        s0 = seen.size(); l0 = seen_last; total_bits = 0;
        for (int w = 0; w < 50; w++) begin
            rd = WIDTH'($urandom);
            rl = int'($urandom_range(1, WIDTH));
            total_bits += rl;
            send_word(rd, rl);
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();
        check_int("t6_last_pulses", seen_last - l0, 50);
        check_int("t6_bit_count", seen.size() - s0, total_bits);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Parallel-to-serial stage directly upstream of the 10101 Mealy sequence detector; drives its serial data_in one bit per enabled clock, MSB-first.
- Accepts variable-length words (1..WIDTH bits) over a valid/ready handshake.
- One-word hold buffer behind the active shift register gives gap-free back-to-back streaming.
- Replaces ad-hoc per-bit driving of the detector input with a reusable, self-checking source.

Parameters:
- WIDTH, 16, maximum word length in bits.
- LEN_W, $clog2(WIDTH+1), width of the length field.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  word offered on in_data/in_len.
- in_ready  output  1  hold buffer can take a word.
- in_data  input  WIDTH  word; bits [in_len-1:0] are sent, MSB-first.
- in_len  input  LEN_W  number of bits to send; legal range 1..WIDTH.
- shift_en  input  1  bit strobe; the current bit is consumed on an edge where shift_en=1.
- data_out  output  1  serial bit; connects to detector data_in.
- out_valid  output  1  data_out carries a real bit.
- last_bit  output  1  data_out is the final bit of the current word.
- busy  output  1  shift register or hold buffer is occupied.
- err_len  output  1  one-cycle pulse: an accepted word had an illegal in_len.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 while rst_n=0, including in_ready.
  - State goes to IDLE; hold buffer is emptied; shift register and bit counter are cleared.
  - Reset mid-word aborts the word; partial bits are not resumed.
- Handshake:
  - in_ready = rst_n & ~hold_full.
  - A word is accepted on a rising edge with in_valid & in_ready.
  - in_valid may stay high across accepts; each accepting edge takes one word.
- Illegal length (in_len=0 or in_len>WIDTH):
  - The word is still accepted (handshake completes) but discarded.
  - err_len=1 for the following cycle only.
  - No bits are emitted and no state change occurs.
- Load alignment: shreg <= in_data << (WIDTH-in_len), so the first sent bit is in_data[in_len-1]; cnt <= in_len.
- States:
  - IDLE: out_valid=0, data_out=0.
    - A legal word accepted while hold is empty loads straight into shreg; next state is SHIFT.
    - Zero latency: the first bit is visible the cycle after the accepting edge.
  - SHIFT: out_valid=1, data_out=shreg[WIDTH-1], last_bit=(cnt==1).
    - shift_en=1 with cnt>1: shreg shifts left by 1 (0 fills in); cnt decrements.
    - shift_en=1 with cnt==1, word ends. Priority for the next word:
      1. If hold is full, hold moves into shreg and cnt, hold empties, stay in SHIFT.
      2. Else if a legal word is accepted on the same edge, it loads directly into shreg, stay in SHIFT.
      3. Else go to IDLE.
    - shift_en=0: all state holds; data_out is stable.
    - A legal word accepted in SHIFT goes into hold (case 2 above excepted).
- Gap-free streaming: with shift_en held at 1, consecutive words produce contiguous out_valid with no idle cycle.
- Simultaneous drain and accept: in_ready is 0 whenever hold is full, so hold is never written on the edge it drains.
- busy = (state==SHIFT) | hold_full.
- Outputs data_out, out_valid and last_bit are derived from registers only (no combinational path from inputs).

Decomposition:
- Shared package pattern_ser_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the default WIDTH;
  - a len_legal(len) function used by both the RTL and the bench scoreboard.
- One natural sub-module: ser_hold_buf (single-entry data+len register with full flag, load/drain strobes).
- The shifter and FSM stay in the top module.

Test Plan:
1. Single 10-bit word: in_data=16'h02B3, in_len=10, shift_en=1 → data_out = 1,0,1,0,1,1,0,0,1,1 over 10 cycles; last_bit only on the 10th; then IDLE with out_valid=0. The downstream detector fires once.
2. Back-to-back: words (5'b10101, len 5) and (5'b10101, len 5) offered consecutively → 10 contiguous valid bits, no gap; in_ready=0 while hold is full.
3. Stall: word 4'b1001 len 4 with shift_en toggling 1,0,0,1,1,0,1 → each bit is held while shift_en=0; exactly 4 consumed bits, sent in order.
4. Illegal lengths: in_len=0, then in_len=17 → both accepted, err_len pulses once each, out_valid stays 0.
5. Reset mid-word: assert rst_n=0 after 3 bits of 16'hFFFF len 16 → outputs 0 immediately (asynchronous); after release the state is IDLE and in_ready=1.
6. Random stream: 50 random words, random legal lengths, random shift_en → serial stream matches the scoreboard bit-for-bit; count of last_bit pulses equals the number of legal words.
